// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_pkg
// Purpose  : Shared constants, state encoding and operand classification for
//            the binary16 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package fpmul_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    localparam logic [15:0] QNAN = 16'h7E00;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_UNPACK = 3'd1;
    localparam state_t ST_MUL    = 3'd2;
    localparam state_t ST_NORM   = 3'd3;
    localparam state_t ST_ROUND  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } op_class_t;

    function automatic op_class_t classify(input logic [15:0] v);
        op_class_t c;
        c = CLS_NORM;
        if (v[FRAC_W +: EXP_W] == '1)
            c = (v[FRAC_W-1:0] != '0) ? CLS_NAN : CLS_INF;
        else if (v[FRAC_W +: EXP_W] == '0)
            c = (v[FRAC_W-1:0] != '0) ? CLS_SUB : CLS_ZERO;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpmul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_round_pack
// Purpose  : Combinational back end: normalize the 22-bit mantissa product,
//            round to nearest-even, apply overflow/underflow and special-case
//            overrides, and pack a binary16 result.
// Ports    : i_prod    - raw 11x11 mantissa product
//            i_exp     - biased exponent sum (two's complement, 7 bit)
//            i_sign    - result sign
//            i_nan     - force canonical qNaN
//            i_inf     - force signed infinity (below NaN)
//            i_zero    - force signed zero (below inf)
//            o_result  - packed binary16 result
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_round_pack
    import fpmul_pkg::*;
(
    input  logic [PROD_W-1:0] i_prod,
    input  logic [6:0]        i_exp,
    input  logic              i_sign,
    input  logic              i_nan,
    input  logic              i_inf,
    input  logic              i_zero,
    output logic [15:0]       o_result
);

    logic signed [7:0]  w_exp_in;
    logic signed [7:0]  w_exp_n;
    logic signed [7:0]  w_exp_f;
    logic [MANT_W-1:0]  w_mant;
    logic [MANT_W-1:0]  w_mant_f;
    logic [MANT_W:0]    w_mant_r;
    logic               w_g;
    logic               w_r;
    logic               w_s;
    logic               w_up;

    assign w_exp_in = {i_exp[6], i_exp};

    always_comb begin
        // Product of two 1.x mantissas lies in [1,4); a set top bit means [2,4)
        if (i_prod[PROD_W-1]) begin
            w_mant  = i_prod[21:11];
            w_g     = i_prod[10];
            w_r     = i_prod[9];
            w_s     = |i_prod[8:0];
            w_exp_n = w_exp_in + 8'sd1;
        end else begin
            w_mant  = i_prod[20:10];
            w_g     = i_prod[9];
            w_r     = i_prod[8];
            w_s     = |i_prod[7:0];
            w_exp_n = w_exp_in;
        end

        // Guard is the half-ulp bit; an exact tie rounds toward an even LSB
        w_up     = w_g & (w_r | w_s | w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_up};

        // Rounding 1.111..1 up yields 2.0: renormalize
        if (w_mant_r[MANT_W]) begin
            w_mant_f = w_mant_r[MANT_W:1];
            w_exp_f  = w_exp_n + 8'sd1;
        end else begin
            w_mant_f = w_mant_r[MANT_W-1:0];
            w_exp_f  = w_exp_n;
        end

        if (i_nan)
            o_result = QNAN;
        else if (i_inf)
            o_result = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (i_zero)
            o_result = {i_sign, 15'h0000};
        else if (w_exp_f >= 8'sd31)
            o_result = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (w_exp_f <= 8'sd0)
            o_result = {i_sign, 15'h0000};
        else
            o_result = {i_sign, w_exp_f[EXP_W-1:0], w_mant_f[FRAC_W-1:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fpmul.sv
`default_nettype none
// ============================================================================
// Module   : fpmul
// Purpose  : Multi-cycle IEEE 754 binary16 multiplier with a fixed 14-cycle
//            schedule (UNPACK, 11x MUL, NORM, ROUND) and a one-cycle result
//            strobe. Subnormals flush to zero on input and output.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-high reset
//            x1    - operand A (binary16)
//            x2    - operand B (binary16)
//            en    - start strobe, operands sampled on the same edge
//            y     - product, held until the next result edge
//            ready - one-cycle result-valid pulse
//            busy  - operation in flight, through the ready cycle
// Revision : 1.0 - initial release
// ============================================================================
module fpmul
    import fpmul_pkg::*;
#(
    parameter int LATENCY = 14
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic        en,
    output logic [15:0] y,
    output logic        ready,
    output logic        busy
);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [15:0]         r_a;
    logic [15:0]         r_b;
    logic [MANT_W-1:0]   r_ma;
    logic [MANT_W-1:0]   r_mb;
    logic [PROD_W-1:0]   r_acc;
    logic [6:0]          r_exp;
    logic                r_sign;
    logic                r_nan;
    logic                r_inf;
    logic                r_zero;
    logic [15:0]         r_y;
    logic                r_ready;

    op_class_t           w_cls_a;
    op_class_t           w_cls_b;
    logic                w_zero_a;
    logic                w_zero_b;
    logic                w_inf_a;
    logic                w_inf_b;
    logic [PROD_W-1:0]   w_pp;
    logic [15:0]         w_result;

    assign w_cls_a  = classify(r_a);
    assign w_cls_b  = classify(r_b);
    assign w_zero_a = (w_cls_a == CLS_ZERO) || (w_cls_a == CLS_SUB);
    assign w_zero_b = (w_cls_b == CLS_ZERO) || (w_cls_b == CLS_SUB);
    assign w_inf_a  = (w_cls_a == CLS_INF);
    assign w_inf_b  = (w_cls_b == CLS_INF);

    // Partial product for the multiplier bit currently at r_mb[0]
    assign w_pp = r_mb[0] ? ({{MANT_W{1'b0}}, r_ma} << r_cnt) : '0;

    // r_acc/r_exp are frozen from NORM onward, so this path has two cycles
    fpmul_round_pack u_round_pack (
        .i_prod   (r_acc),
        .i_exp    (r_exp),
        .i_sign   (r_sign),
        .i_nan    (r_nan),
        .i_inf    (r_inf),
        .i_zero   (r_zero),
        .o_result (w_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_exp   <= 7'd0;
            r_sign  <= 1'b0;
            r_nan   <= 1'b0;
            r_inf   <= 1'b0;
            r_zero  <= 1'b0;
            r_y     <= 16'h0000;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_a     <= x1;
                        r_b     <= x2;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_sign  <= r_a[15] ^ r_b[15];
                    r_ma    <= {1'b1, r_a[FRAC_W-1:0]};
                    r_mb    <= {1'b1, r_b[FRAC_W-1:0]};
                    r_exp   <= {2'b00, r_a[FRAC_W +: EXP_W]}
                             + {2'b00, r_b[FRAC_W +: EXP_W]}
                             - 7'(BIAS);
                    // Invalid (NaN in, or inf x zero) collapses into one flag
                    r_nan   <= (w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN)
                             || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);
                    r_inf   <= w_inf_a || w_inf_b;
                    r_zero  <= w_zero_a || w_zero_b;
                    r_acc   <= '0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    r_acc <= r_acc + w_pp;
                    r_mb  <= r_mb >> 1;
                    if (r_cnt == 4'(MANT_W - 1)) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_NORM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_NORM: begin
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_y     <= w_result;
                    r_ready <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // Returning to idle on this edge; a start strobe on the
                    // same edge is accepted so back-to-back ops take 15 cycles
                    if (en) begin
                        r_a     <= x1;
                        r_b     <= x2;
                        r_state <= ST_UNPACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign y     = r_y;
    assign ready = r_ready;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
